// File: rtl/mtsp_memory_command_arbiter.sv
// Memory-command arbiter: two priority classes with shared round-robin, a
// low-priority starvation guard, burst lock and one registered output slot.
module mtsp_memory_command_arbiter #(
  parameter int REQ_COUNT    = 4,
  parameter int DESC_WIDTH   = 256,
  parameter int STARVE_LIMIT = 8,
  parameter int ID_WIDTH     = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [REQ_COUNT-1:0]            REQ_EN,
  input  logic [REQ_COUNT-1:0]            REQ_PRIO,
  input  logic [REQ_COUNT-1:0]            REQ_LOCK,
  input  logic [REQ_COUNT*DESC_WIDTH-1:0] REQ_DESC,
  output logic [REQ_COUNT-1:0]            REQ_READY,
  output logic                            CMD_EN,
  output logic [DESC_WIDTH-1:0]           CMD_DESC,
  output logic [ID_WIDTH-1:0]             CMD_ID,
  input  logic                            CMD_READY,
  output logic                            BUSY
);

  typedef enum logic {LOCK_IDLE, LOCK_HELD} lock_state_t;

  localparam logic [ID_WIDTH:0] REQ_COUNT_W = (ID_WIDTH+1)'(REQ_COUNT);
  localparam logic [3:0]        STARVE_W    = 4'(STARVE_LIMIT);

  lock_state_t           lock_state_reg, lock_state_next;
  logic [ID_WIDTH-1:0]   lock_owner_reg, lock_owner_next;
  logic [ID_WIDTH-1:0]   rr_ptr_reg;
  logic [3:0]            starve_cnt_reg, starve_cnt_next;
  logic                  cmd_en_reg;
  logic [DESC_WIDTH-1:0] cmd_desc_reg;
  logic [ID_WIDTH-1:0]   cmd_id_reg;

  logic [DESC_WIDTH-1:0] desc_arr [REQ_COUNT];
  logic [REQ_COUNT-1:0]  hi_req, lo_req, owner_req, eligible;
  logic                  out_free, starving, win_valid, transfer;
  logic [ID_WIDTH-1:0]   winner;
  logic [ID_WIDTH:0]     rr_after;

  assign out_free = ~cmd_en_reg | CMD_READY;
  assign hi_req   = REQ_EN & REQ_PRIO;
  assign lo_req   = REQ_EN & ~REQ_PRIO;
  assign starving = (starve_cnt_reg >= STARVE_W) && (|lo_req);

  generate
    for (genvar gi = 0; gi < REQ_COUNT; gi++) begin : g_req
      assign desc_arr[gi]  = REQ_DESC[gi*DESC_WIDTH +: DESC_WIDTH];
      assign owner_req[gi] = REQ_EN[gi] && (lock_owner_reg == ID_WIDTH'(gi));
      assign REQ_READY[gi] = win_valid && out_free && !RST && (winner == ID_WIDTH'(gi));
    end
  endgenerate

  always_comb begin
    eligible = lo_req;
    if (lock_state_reg == LOCK_HELD) eligible = owner_req;
    else if (starving)               eligible = lo_req;
    else if (|hi_req)                eligible = hi_req;
  end

  // Round-robin scan starting at rr_ptr, wrapping at REQ_COUNT.
  always_comb begin
    logic [ID_WIDTH:0] idx;
    win_valid = 1'b0;
    winner    = '0;
    idx       = '0;
    for (int k = 0; k < REQ_COUNT; k++) begin
      idx = {1'b0, rr_ptr_reg} + (ID_WIDTH+1)'(k);
      if (idx >= REQ_COUNT_W) idx = idx - REQ_COUNT_W;
      if (!win_valid && eligible[idx[ID_WIDTH-1:0]]) begin
        win_valid = 1'b1;
        winner    = idx[ID_WIDTH-1:0];
      end
    end
  end

  assign transfer = win_valid && out_free && !RST;

  always_comb begin
    rr_after = {1'b0, winner} + 1'b1;
    if (rr_after >= REQ_COUNT_W) rr_after = '0;
  end

  always_comb begin
    lock_state_next = lock_state_reg;
    lock_owner_next = lock_owner_reg;
    case (lock_state_reg)
      LOCK_IDLE: begin
        if (transfer && REQ_LOCK[winner]) begin
          lock_state_next = LOCK_HELD;
          lock_owner_next = winner;
        end
      end
      LOCK_HELD: begin
        // Only the owner can transfer here, so winner is the owner.
        if (transfer && !REQ_LOCK[winner]) lock_state_next = LOCK_IDLE;
      end
      default: lock_state_next = LOCK_IDLE;
    endcase
  end

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!(|lo_req)) begin
      starve_cnt_next = '0;
    end else if (transfer) begin
      if (!REQ_PRIO[winner])           starve_cnt_next = '0;
      else if (starve_cnt_reg != 4'hF) starve_cnt_next = starve_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lock_state_reg <= LOCK_IDLE;
      lock_owner_reg <= '0;
      rr_ptr_reg     <= '0;
      starve_cnt_reg <= '0;
      cmd_en_reg     <= 1'b0;
      cmd_desc_reg   <= '0;
      cmd_id_reg     <= '0;
    end else begin
      lock_state_reg <= lock_state_next;
      lock_owner_reg <= lock_owner_next;
      starve_cnt_reg <= starve_cnt_next;
      if (transfer) begin
        rr_ptr_reg   <= rr_after[ID_WIDTH-1:0];
        cmd_en_reg   <= 1'b1;
        cmd_desc_reg <= desc_arr[winner];
        cmd_id_reg   <= winner;
      end else if (CMD_READY) begin
        cmd_en_reg   <= 1'b0;
      end
    end
  end

  assign CMD_EN   = cmd_en_reg;
  assign CMD_DESC = cmd_desc_reg;
  assign CMD_ID   = cmd_id_reg;
  assign BUSY     = cmd_en_reg | (lock_state_reg == LOCK_HELD);

endmodule

// File: tb/tb_mtsp_memory_command_arbiter.sv
// Directed bench for mtsp_memory_command_arbiter: reset, fairness, starvation,
// backpressure, lock bursts and reset while locked.
module tb_mtsp_memory_command_arbiter;

  localparam int N  = 4;
  localparam int DW = 256;
  localparam int IW = 2;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    REQ_EN, REQ_PRIO, REQ_LOCK, REQ_READY;
  logic [N*DW-1:0] REQ_DESC;
  logic            CMD_EN, CMD_READY, BUSY;
  logic [DW-1:0]   CMD_DESC;
  logic [IW-1:0]   CMD_ID;

  int checks = 0;
  int errors = 0;

  mtsp_memory_command_arbiter #(
    .REQ_COUNT(N), .DESC_WIDTH(DW), .STARVE_LIMIT(3), .ID_WIDTH(IW)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ_EN(REQ_EN), .REQ_PRIO(REQ_PRIO),
    .REQ_LOCK(REQ_LOCK), .REQ_DESC(REQ_DESC), .REQ_READY(REQ_READY),
    .CMD_EN(CMD_EN), .CMD_DESC(CMD_DESC), .CMD_ID(CMD_ID),
    .CMD_READY(CMD_READY), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic [DW-1:0] desc_of(input int i);
    return {8{32'hD0C0_0000 | 32'(i)}};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_descs();
    for (int i = 0; i < N; i++) REQ_DESC[i*DW +: DW] = desc_of(i);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    int seq_fair [4]  = '{0, 2, 0, 2};
    int seq_starv [8] = '{1, 1, 1, 3, 1, 1, 1, 3};

    // Reset held two cycles with random inputs
    RST = 1'b1;
    for (int c = 0; c < 2; c++) begin
      REQ_EN    = 4'($urandom);
      REQ_PRIO  = 4'($urandom);
      REQ_LOCK  = 4'($urandom);
      CMD_READY = 1'($urandom);
      for (int i = 0; i < N*DW/32; i++) REQ_DESC[i*32 +: 32] = $urandom;
      tick();
      check("rst_cmd_en", DW'(CMD_EN), '0);
      check("rst_busy",   DW'(BUSY),   '0);
      check("rst_ready",  DW'(REQ_READY), '0);
    end
    load_descs();
    REQ_EN = 4'b1111; REQ_PRIO = 4'b0000; REQ_LOCK = 4'b0000; CMD_READY = 1'b1;
    RST = 1'b0;
    #1;
    check("first_ready", DW'(REQ_READY), DW'(4'b0001));
    tick();
    check("first_en",   DW'(CMD_EN), DW'(1));
    check("first_id",   DW'(CMD_ID), DW'(0));
    check("first_desc", CMD_DESC, desc_of(0));
    REQ_EN = 4'b0000;
    tick();
    check("drain_en", DW'(CMD_EN), '0);

    // Low-priority fairness between requesters 0 and 2
    do_reset();
    REQ_EN = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("fair_en%0d", k), DW'(CMD_EN), DW'(1));
      check($sformatf("fair_id%0d", k), DW'(CMD_ID), DW'(seq_fair[k]));
      check($sformatf("fair_desc%0d", k), CMD_DESC, desc_of(seq_fair[k]));
    end

    // Starvation guard: high 1 vs low 3
    do_reset();
    REQ_EN = 4'b1010; REQ_PRIO = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("starve_id%0d", k), DW'(CMD_ID), DW'(seq_starv[k]));
    end

    // Backpressure: slot held for 5 cycles, then drain and refill together
    do_reset();
    REQ_EN = 4'b0001; REQ_PRIO = 4'b0000;
    tick();
    check("bp_first_id", DW'(CMD_ID), DW'(0));
    REQ_EN = 4'b0100; CMD_READY = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_ready%0d", k), DW'(REQ_READY), '0);
      tick();
      check($sformatf("bp_en%0d", k),   DW'(CMD_EN), DW'(1));
      check($sformatf("bp_id%0d", k),   DW'(CMD_ID), DW'(0));
      check($sformatf("bp_desc%0d", k), CMD_DESC, desc_of(0));
    end
    CMD_READY = 1'b1;
    #1;
    check("bp_refill_ready", DW'(REQ_READY), DW'(4'b0100));
    tick();
    check("bp_refill_id",   DW'(CMD_ID), DW'(2));
    check("bp_refill_desc", CMD_DESC, desc_of(2));
    REQ_EN = 4'b0000;

    // Lock burst from requester 2 with high-priority requester 0 pending
    do_reset();
    REQ_EN = 4'b0100; REQ_PRIO = 4'b0000; REQ_LOCK = 4'b0100;
    #1;
    check("lock_ready1", DW'(REQ_READY), DW'(4'b0100));
    tick();
    check("lock_id1",   DW'(CMD_ID), DW'(2));
    check("lock_busy1", DW'(BUSY), DW'(1));
    REQ_EN = 4'b0101; REQ_PRIO = 4'b0001;
    #1;
    check("lock_ready2", DW'(REQ_READY), DW'(4'b0100));
    tick();
    check("lock_id2", DW'(CMD_ID), DW'(2));
    REQ_EN = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("lock_gap_ready%0d", k), DW'(REQ_READY), '0);
      tick();
      check($sformatf("lock_gap_en%0d", k),   DW'(CMD_EN), '0);
      check($sformatf("lock_gap_busy%0d", k), DW'(BUSY), DW'(1));
    end
    REQ_EN = 4'b0101; REQ_LOCK = 4'b0000;
    #1;
    check("lock_ready3", DW'(REQ_READY), DW'(4'b0100));
    tick();
    check("lock_id3",   DW'(CMD_ID), DW'(2));
    check("lock_busy3", DW'(BUSY), DW'(1));
    REQ_EN = 4'b0001;
    #1;
    check("unlock_ready", DW'(REQ_READY), DW'(4'b0001));
    tick();
    check("unlock_id", DW'(CMD_ID), DW'(0));
    REQ_EN = 4'b0000;
    tick();
    check("unlock_busy", DW'(BUSY), '0);
    check("unlock_en",   DW'(CMD_EN), '0);

    // Reset while locked with an occupied output slot
    do_reset();
    REQ_EN = 4'b0100; REQ_PRIO = 4'b0000; REQ_LOCK = 4'b0100;
    tick();
    check("rl_en",   DW'(CMD_EN), DW'(1));
    check("rl_busy", DW'(BUSY), DW'(1));
    RST = 1'b1; REQ_EN = 4'b0110; REQ_LOCK = 4'b0000; CMD_READY = 1'b0;
    #1;
    check("rl_rst_ready", DW'(REQ_READY), '0);
    tick();
    RST = 1'b0; CMD_READY = 1'b1;
    check("rl_after_en",   DW'(CMD_EN), '0);
    check("rl_after_busy", DW'(BUSY), '0);
    #1;
    check("rl_ready", DW'(REQ_READY), DW'(4'b0010));
    tick();
    check("rl_id", DW'(CMD_ID), DW'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
